iterative_arithmetic_right_shifter: RTL and testbench
=====================================================

ITERATIVE_ARITHMETIC_RIGHT_SHIFTER -- requirements
Module: iterative_arithmetic_right_shifter

Interface
REQ-001 Parameter WIDTH, default 16, data width of A, B and Y.
REQ-002 Parameter SHAMT_W, default 4, number of low bits of B used as the shift amount.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 A  input  WIDTH  signed operand to be shifted.
REQ-007 B  input  WIDTH  shift amount source; only B[SHAMT_W-1:0] is used, upper bits ignored.
REQ-008 Y  output  WIDTH  registered result A >>> shamt.
REQ-009 sticky  output  1  registered OR of all bits shifted out of A (information-loss flag).
REQ-010 busy  output  1  high while a request is in progress (SHIFT or DONE).
REQ-011 done  output  1  one-cycle pulse marking Y/sticky valid for the completed request.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-013 In IDLE with start=1 at edge t, the block SHALL load work register W=A, counter C=B[SHAMT_W-1:0], sticky accumulator S=0, and go to DONE if C==0, else to SHIFT.
REQ-014 Each SHIFT cycle SHALL perform W <= {W[WIDTH-1], W[WIDTH-1:1]}, S <= S | W[0], C <= C-1; the state moves to DONE on the edge where C==1.
REQ-015 For shift amount N, SHIFT SHALL last exactly N cycles and done SHALL be high in cycle t+N+1 (latency N+1; N=0 gives latency 1).
REQ-016 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-017 Y and sticky SHALL update only on the edge entering DONE (Y<=final W, sticky<=final S) and hold until the next request completes; intermediate shift values are never visible on Y.
REQ-018 busy SHALL equal (state!=IDLE); done SHALL equal (state==DONE).
REQ-019 start while busy (including during DONE) SHALL be ignored with no effect on W, C, S, Y or sticky; A and B need not be held stable after the accept edge.
REQ-020 Sign fill SHALL use the operand's MSB; a negative operand shifted by WIDTH-1 yields all ones, a non-negative one yields zero.
REQ-021 The shift amount SHALL be treated as unsigned; maximum N=2^SHAMT_W-1, with no wrap or saturation of C.

Reset
REQ-022 Assertion of rst_n=0 SHALL immediately force state=IDLE, W=0, C=0, S=0, Y=0, sticky=0, busy=0, done=0, aborting any in-progress request without a done pulse.
REQ-023 After deassertion, the first start SHALL be accepted on the first rising edge at which rst_n=1 and start=1.

Structure
REQ-024 A shared package SHALL hold the FSM state typedef (IDLE, SHIFT, DONE) and the default constants WIDTH=16, SHAMT_W=4.
REQ-025 The down-counter SHALL be a separate sub-module named shift_count_down (load, decrement, last-count flag); the datapath and FSM stay in this module.

Verification
REQ-026 A=0x8000, B=0x000F, start at edge t -> done only at cycle t+16, Y=0xFFFF, sticky=0, busy high cycles t+1..t+16.
REQ-027 A=0x7FFF, B=0x0004 -> done at t+5, Y=0x07FF, sticky=1.
REQ-028 A=0x1234, B=0x0000 -> done at t+1, Y=0x1234, sticky=0; B=0xFFF2, A=0xC003 -> shamt 2, Y=0xF000, sticky=1.
REQ-029 Request A=0x0100,B=3 in flight, new start with A=0xFFFF,B=1 pulsed at t+2 and in DONE -> ignored; result Y=0x0020, sticky=0, exactly one done pulse.
REQ-030 rst_n driven low mid-SHIFT (A=0x4000,B=8, at t+3) -> outputs zero asynchronously, no done; after release, A=0xF0F0,B=4 -> Y=0xFF0F, sticky=0, done at t'+5.

Source files
------------

// File: rtl/iterative_arithmetic_right_shifter_pkg.sv
// Shared FSM state encoding and default geometry for the iterative arithmetic right shifter.
// No logic; imported by the shifter top.
package iterative_arithmetic_right_shifter_pkg;

  localparam int DEFAULT_WIDTH   = 16;
  localparam int DEFAULT_SHAMT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_count_down.sv
// Loadable down-counter that flags the final count (value 1).
// Load wins over decrement. The flag is combinational from the held count.
module shift_count_down #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             last
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == CNT_ONE);

endmodule

// File: rtl/iterative_arithmetic_right_shifter.sv
// Arithmetic right shift by B[SHAMT_W-1:0], one bit per cycle; done pulses N+1 cycles after accept.
// start is only honoured in IDLE; requests arriving while busy are dropped.
module iterative_arithmetic_right_shifter
  import iterative_arithmetic_right_shifter_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int SHAMT_W = DEFAULT_SHAMT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Y,
  output logic             sticky,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] w_q, w_d;
  logic             s_q, s_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             sticky_q, sticky_d;
  logic             busy_q;
  logic             done_q;

  logic [SHAMT_W-1:0] shamt;
  logic               cnt_load;
  logic               cnt_dec;
  logic               cnt_last;

  assign shamt = B[SHAMT_W-1:0];

  generate
    if (SHAMT_W < WIDTH) begin : g_b_upper
      logic unused_b_upper;
      assign unused_b_upper = ^B[WIDTH-1:SHAMT_W];
    end
  endgenerate

  shift_count_down #(
    .CNT_W(SHAMT_W)
  ) u_count (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (shamt),
    .dec      (cnt_dec),
    .last     (cnt_last)
  );

  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    s_d      = s_q;
    y_d      = y_q;
    sticky_d = sticky_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          w_d      = A;
          s_d      = 1'b0;
          cnt_load = 1'b1;
          if (shamt == '0) begin
            // Zero shift completes straight away with the operand untouched.
            state_d  = DONE;
            y_d      = A;
            sticky_d = 1'b0;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        w_d     = {w_q[WIDTH-1], w_q[WIDTH-1:1]};
        s_d     = s_q | w_q[0];
        cnt_dec = 1'b1;
        if (cnt_last) begin
          state_d  = DONE;
          y_d      = w_d;
          sticky_d = s_d;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      w_q      <= '0;
      s_q      <= 1'b0;
      y_q      <= '0;
      sticky_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      s_q      <= s_d;
      y_q      <= y_d;
      sticky_q <= sticky_d;
      busy_q   <= (state_d != IDLE);
      done_q   <= (state_d == DONE);
    end
  end

  assign Y      = y_q;
  assign sticky = sticky_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_iterative_arithmetic_right_shifter.sv
// Directed-vector bench for the iterative arithmetic right shifter.
// Checks latency, busy window, result hold, ignored starts and async reset abort.
module tb_iterative_arithmetic_right_shifter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] Y;
  logic        sticky;
  logic        busy;
  logic        done;

  int total;
  int bad;

  iterative_arithmetic_right_shifter #(
    .WIDTH   (16),
    .SHAMT_W (4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .A      (A),
    .B      (B),
    .Y      (Y),
    .sticky (sticky),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request and watch it for n+3 cycles; optionally pulse start
  // with a conflicting operand mid-shift and during DONE.
  task automatic do_req(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input int n, input logic [15:0] exp_y, input logic exp_s,
                        input bit poke);
    int          done_at;
    int          done_cnt;
    int          busy_bad;
    int          y_early;
    logic [15:0] prev_y;
    logic        prev_s;
    @(negedge clk);
    prev_y = Y;
    prev_s = sticky;
    A      = a;
    B      = b;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A     = 16'($urandom);
    B     = 16'($urandom);
    done_at  = -1;
    done_cnt = 0;
    busy_bad = 0;
    y_early  = 0;
    for (int k = 1; k <= n + 3; k++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (k <= n + 1 && !busy) busy_bad++;
      if (k >= n + 2 && busy) busy_bad++;
      if (k <= n && (Y !== prev_y || sticky !== prev_s)) y_early++;
      if (poke && (k == 2 || k == n + 1)) begin
        A     = 16'hFFFF;
        B     = 16'h0001;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    check_val({tag, " done_cycle"}, 32'(done_at), 32'(n + 1));
    check_val({tag, " done_count"}, 32'(done_cnt), 32'd1);
    check_val({tag, " busy_window"}, 32'(busy_bad), 32'd0);
    check_val({tag, " y_early"}, 32'(y_early), 32'd0);
    check_val({tag, " Y"}, 32'(Y), 32'(exp_y));
    check_val({tag, " sticky"}, 32'(sticky), 32'(exp_s));
  endtask

  initial begin
    int done_seen;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    A     = 16'h0;
    B     = 16'h0;
    #12;
    check_val("rst Y", 32'(Y), 32'h0);
    check_val("rst sticky", 32'(sticky), 32'h0);
    check_val("rst busy", 32'(busy), 32'h0);
    check_val("rst done", 32'(done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    do_req("min_neg15", 16'h8000, 16'h000F, 15, 16'hFFFF, 1'b0, 1'b0);
    do_req("max_pos4",  16'h7FFF, 16'h0004, 4,  16'h07FF, 1'b1, 1'b0);
    do_req("zero_sh",   16'h1234, 16'h0000, 0,  16'h1234, 1'b0, 1'b0);
    do_req("upper_b",   16'hC003, 16'hFFF2, 2,  16'hF000, 1'b1, 1'b0);
    do_req("upper_b0",  16'h5A5A, 16'h00F0, 0,  16'h5A5A, 1'b0, 1'b0);
    do_req("pos15",     16'h7FFF, 16'h000F, 15, 16'h0000, 1'b1, 1'b0);
    do_req("neg1",      16'h8000, 16'h0001, 1,  16'hC000, 1'b0, 1'b0);
    do_req("ignore",    16'h0100, 16'h0003, 3,  16'h0020, 1'b0, 1'b1);

    // Abort a request mid-shift with an asynchronous reset.
    @(negedge clk);
    A     = 16'h4000;
    B     = 16'h0008;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("abort Y", 32'(Y), 32'h0);
    check_val("abort sticky", 32'(sticky), 32'h0);
    check_val("abort busy", 32'(busy), 32'h0);
    check_val("abort done", 32'(done), 32'h0);
    done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) done_seen++;
      if (k == 2) rst_n = 1'b1;
    end
    check_val("abort no_done", 32'(done_seen), 32'd0);
    do_req("after_rst", 16'hF0F0, 16'h0004, 4, 16'hFF0F, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
